// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the 1-bpp VGA frame-buffer writer.
// The optional frame clear is built only when VGA_FB_CLEAR_EN is defined.
package vga_pkg;

    localparam int H_PIXELS   = 800;
    localparam int V_PIXELS   = 480;
    localparam int WORD_BITS  = 16;
    localparam int FB_WORDS   = H_PIXELS * V_PIXELS / WORD_BITS;
    localparam int ADDR_BITS  = 16;
    localparam int COORD_BITS = 11;

    // IDLE is encoded as zero so a debug probe reads 0 whenever the block is idle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WRITE  = 3'd3
`ifdef VGA_FB_CLEAR_EN
        ,
        ST_CLEAR  = 3'd4
`endif
    } fb_state_t;

    function automatic int bit_index_width(input int word_bits);
        return (word_bits > 1) ? $clog2(word_bits) : 1;
    endfunction

endpackage

// File: rtl/vga_pixel_addr.sv
// Combinational pixel-to-RAM mapping: (x, y) -> word address, bit index, in-range flag.
// Shared by the write path and the display read path.
module vga_pixel_addr
    import vga_pkg::*;
#(
    parameter int H_PIXELS  = vga_pkg::H_PIXELS,
    parameter int V_PIXELS  = vga_pkg::V_PIXELS,
    parameter int WORD_BITS = vga_pkg::WORD_BITS,
    parameter int BIT_W     = vga_pkg::bit_index_width(vga_pkg::WORD_BITS)
) (
    input  logic [COORD_BITS-1:0] x_i,
    input  logic [COORD_BITS-1:0] y_i,
    output logic [ADDR_BITS-1:0]  word_addr_o,
    output logic [BIT_W-1:0]      bit_idx_o,
    output logic                  in_range_o
);

    logic [31:0] pix_num;

    // Linear pixel number is formed at 32 bits so off-screen coordinates cannot wrap.
    assign pix_num     = 32'(y_i) * 32'(H_PIXELS) + 32'(x_i);
    assign word_addr_o = ADDR_BITS'(pix_num >> BIT_W);
    assign bit_idx_o   = pix_num[BIT_W-1:0];
    assign in_range_o  = (32'(x_i) < 32'(H_PIXELS)) && (32'(y_i) < 32'(V_PIXELS));

endmodule

// File: rtl/vga_fb_writer.sv
// Read-modify-write pixel plotter for a 1-bpp frame buffer in registered RAM.
// Define VGA_FB_CLEAR_EN to build the whole-frame clear engine.
module vga_fb_writer
#(
    parameter int H_PIXELS  = vga_pkg::H_PIXELS,
    parameter int V_PIXELS  = vga_pkg::V_PIXELS,
    parameter int WORD_BITS = vga_pkg::WORD_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 px_valid,
    output logic                 px_ready,
    input  logic [10:0]          px_x,
    input  logic [10:0]          px_y,
    input  logic                 px_colour,
    input  logic                 clear_req,
    input  logic                 clear_colour,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 px_err,
    output logic [15:0]          ram_rd_address,
    input  logic [WORD_BITS-1:0] ram_rd_data,
    output logic [15:0]          ram_wr_address,
    output logic [WORD_BITS-1:0] ram_wr_data,
    output logic                 ram_we,
    output logic [2:0]           dbg_state
);

    import vga_pkg::*;

    localparam int BIT_W = bit_index_width(WORD_BITS);

    // Handshake: a pixel transfers on any rising edge where px_valid && px_ready;
    // px_ready is a pure function of state and clear_req, never of px_valid.

    fb_state_t              state_q, state_d;
    logic [15:0]            rd_addr_q, rd_addr_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   colour_q, colour_d;
    logic [15:0]            wr_addr_q, wr_addr_d;
    logic [WORD_BITS-1:0]   wr_data_q, wr_data_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic [ADDR_BITS-1:0]   map_word;
    logic [BIT_W-1:0]       map_bit;
    logic                   map_in_range;
    logic                   clear_start;
    logic                   we_c;
    logic                   ready_c;
    logic [WORD_BITS-1:0]   mod_word;

    vga_pixel_addr #(
        .H_PIXELS  (H_PIXELS),
        .V_PIXELS  (V_PIXELS),
        .WORD_BITS (WORD_BITS),
        .BIT_W     (BIT_W)
    ) u_pixel_addr (
        .x_i         (px_x),
        .y_i         (px_y),
        .word_addr_o (map_word),
        .bit_idx_o   (map_bit),
        .in_range_o  (map_in_range)
    );

`ifdef VGA_FB_CLEAR_EN
    localparam int          N_WORDS   = H_PIXELS * V_PIXELS / WORD_BITS;
    localparam logic [15:0] LAST_ADDR = 16'(N_WORDS - 1);

    assign clear_start = clear_req;
`else
    logic unused_clear;

    assign clear_start  = 1'b0;
    assign unused_clear = ^{clear_req, clear_colour};
`endif

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        bit_d     = bit_q;
        colour_d  = colour_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        we_c      = 1'b0;
        ready_c   = 1'b0;

        mod_word          = ram_rd_data;
        mod_word[bit_q]   = colour_q;

        case (state_q)
            ST_IDLE: begin
                ready_c = !clear_start;
                if (clear_start) begin
`ifdef VGA_FB_CLEAR_EN
                    // The clear walks the write address register itself as its counter.
                    state_d   = ST_CLEAR;
                    wr_addr_d = '0;
                    wr_data_d = {WORD_BITS{clear_colour}};
`endif
                end else if (px_valid) begin
                    if (map_in_range) begin
                        state_d   = ST_READ;
                        rd_addr_d = map_word;
                        bit_d     = map_bit;
                        colour_d  = px_colour;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_MODIFY;
            end
            ST_MODIFY: begin
                wr_addr_d = rd_addr_q;
                wr_data_d = mod_word;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                we_c    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef VGA_FB_CLEAR_EN
            ST_CLEAR: begin
                we_c = 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_addr_d = wr_addr_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            bit_q     <= '0;
            colour_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            bit_q     <= bit_d;
            colour_q  <= colour_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign px_ready       = ready_c;
    assign busy           = (state_q != ST_IDLE);
    assign ram_we         = we_c;
    assign ram_rd_address = rd_addr_q;
    assign ram_wr_address = wr_addr_q;
    assign ram_wr_data    = wr_data_q;
    assign px_err         = err_q;
    assign clear_done     = done_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Bench for vga_fb_writer: registered RAM, pixel-level frame model, directed and random steps.
// Clear behaviour is checked according to whether VGA_FB_CLEAR_EN is defined.
module tb_vga_fb_writer;

    localparam int H     = 800;
    localparam int V     = 480;
    localparam int WB    = 16;
    localparam int WORDS = H * V / WB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [10:0] px_x = '0;
    logic [10:0] px_y = '0;
    logic        px_colour = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_colour = 1'b0;
    logic        busy;
    logic        clear_done;
    logic        px_err;
    logic [15:0] ram_rd_address;
    logic [15:0] ram_rd_data;
    logic [15:0] ram_wr_address;
    logic [15:0] ram_wr_data;
    logic        ram_we;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    vga_fb_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .px_x           (px_x),
        .px_y           (px_y),
        .px_colour      (px_colour),
        .clear_req      (clear_req),
        .clear_colour   (clear_colour),
        .busy           (busy),
        .clear_done     (clear_done),
        .px_err         (px_err),
        .ram_rd_address (ram_rd_address),
        .ram_rd_data    (ram_rd_data),
        .ram_wr_address (ram_wr_address),
        .ram_wr_data    (ram_wr_data),
        .ram_we         (ram_we),
        .dbg_state      (dbg_state)
    );

    // Registered RAM with a side port so the bench can preload words.
    bit [15:0]   mem [WORDS];
    bit [15:0]   rd_q;
    logic        tb_wr = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [15:0] tb_data = '0;

    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            if (ram_wr_address < WORDS) mem[ram_wr_address] <= ram_wr_data;
        end else if (tb_wr) begin
            mem[tb_addr] <= tb_data;
        end
        if (ram_rd_address < WORDS) rd_q <= mem[ram_rd_address];
        else rd_q <= 16'hDEAD;
    end
    assign ram_rd_data = rd_q;

    logic [31:0] wr_q [$];
    int          n_we = 0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_q.push_back({ram_wr_address, ram_wr_data});
            n_we++;
        end
        if (clear_done === 1'b1) n_done++;
    end

    // Reference frame: one word per 16 pixels, updated pixel by pixel.
    bit [15:0]   exp_mem [WORDS];
    logic [31:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_frame(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    task automatic model_pixel(input int x, input int y, input logic c);
        int pn;
        int w;
        int b;
        pn = y * H + x;
        w  = pn / WB;
        b  = pn % WB;
        exp_mem[w][b] = c;
        exp_q.push_back({16'(w), exp_mem[w]});
    endtask

    task automatic preload(input int addr, input logic [15:0] data);
        tb_wr   = 1'b1;
        tb_addr = 16'(addr);
        tb_data = data;
        step();
        tb_wr   = 1'b0;
        exp_mem[addr] = data;
    endtask

    task automatic do_pixel(input int x, input int y, input logic c);
        logic [31:0] exp_wr;
        px_x      = 11'(x);
        px_y      = 11'(y);
        px_colour = c;
        px_valid  = 1'b1;
        check("px_ready_before_transfer", px_ready, 1);
        step();
        px_valid = 1'b0;
        if (!in_frame(x, y)) begin
            check("oor_px_err_pulse", px_err, 1);
            check("oor_no_we", ram_we, 0);
            check("oor_not_busy", busy, 0);
            check("oor_ready_next", px_ready, 1);
            step();
            check("oor_px_err_single", px_err, 0);
            check("oor_no_we_later", ram_we, 0);
        end else begin
            model_pixel(x, y, c);
            exp_wr = exp_q.pop_front();
            check("read_busy", busy, 1);
            check("read_no_we", ram_we, 0);
            check("read_address", ram_rd_address, exp_wr[31:16]);
            step();
            check("modify_no_we", ram_we, 0);
            step();
            check("write_we", ram_we, 1);
            check("write_addr_data", {ram_wr_address, ram_wr_data}, exp_wr);
            step();
            check("write_we_single", ram_we, 0);
            check("ready_after_write", px_ready, 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int last;
        int n;
        int bad;
        int nw;
        int we0;
        int x;
        int y;
        logic c;

        // Reset values
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_we", ram_we, 0);
        reset_n = 1'b1;
        step();
        check("rst_px_ready", px_ready, 1);
        check("rst_busy_after", busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_px_err", px_err, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_rd_addr", ram_rd_address, 0);
        check("rst_wr_addr", ram_wr_address, 0);
        check("rst_wr_data", ram_wr_data, 0);
        check("rst_dbg_idle", dbg_state, 0);

        // Pixel (0,0) white onto a zero word
        do_pixel(0, 0, 1'b1);
        // Pixel (17,1) black onto an all-ones word
        preload(51, 16'hFFFF);
        do_pixel(17, 1, 1'b0);
        // First column past the right edge
        do_pixel(800, 0, 1'b1);
        do_pixel(0, 480, 1'b1);

        // Random pixels, some clustered to revisit the same words
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) begin
                x = $urandom_range(0, 31);
                y = $urandom_range(0, 1);
            end else begin
                x = $urandom_range(0, 860);
                y = $urandom_range(0, 520);
            end
            c = 1'($urandom_range(0, 1));
            do_pixel(x, y, c);
        end

        // Back-to-back with px_valid held high
        base = wr_q.size();
        last = 0;
        px_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            x = (k % 2 == 0) ? $urandom_range(0, 799) : $urandom_range(0, 20);
            y = (k % 2 == 0) ? $urandom_range(0, 479) : 0;
            px_x      = 11'(x);
            px_y      = 11'(y);
            px_colour = 1'($urandom_range(0, 1));
            n = 0;
            while (px_ready !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            check("b2b_ready_in_time", px_ready, 1);
            if (k > 0) check("b2b_gap", cyc - last, 4);
            last = cyc;
            model_pixel(x, y, px_colour);
            step();
        end
        px_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("b2b_write_count", wr_q.size() - base, exp_q.size());
        for (int i = 0; i < 8 && base + i < wr_q.size(); i++) begin
            check("b2b_write", wr_q[base + i], exp_q.pop_front());
        end

`ifdef VGA_FB_CLEAR_EN
        // Clear wins over a simultaneous pixel; a clear_req mid-clear is ignored
        base = n_done;
        clear_colour = 1'b1;
        clear_req    = 1'b1;
        px_x = 11'd5; px_y = 11'd5; px_colour = 1'b0;
        px_valid = 1'b1;
        check("clr_wins_ready_low", px_ready, 0);
        step();
        clear_req = 1'b0;
        px_valid  = 1'b0;
        check("clr_busy", busy, 1);
        bad = 0;
        nw  = 0;
        n   = 0;
        while (clear_done !== 1'b1 && n < WORDS + 20) begin
            if (ram_we === 1'b1) begin
                if (ram_wr_address !== 16'(nw) || ram_wr_data !== 16'hFFFF) bad++;
                nw++;
            end
            clear_req    = (n == 50);
            clear_colour = (n == 50) ? 1'b0 : 1'b1;
            step();
            n++;
        end
        clear_req = 1'b0;
        check("clr_done_seen", clear_done, 1);
        check("clr_word_count", nw, WORDS);
        check("clr_bad_words", bad, 0);
        check("clr_idle_at_done", busy, 0);
        check("clr_no_we_at_done", ram_we, 0);
        check("clr_gap_to_done", n, WORDS);
        step();
        check("clr_done_single", clear_done, 0);
        check("clr_done_pulses", n_done - base, 1);
        for (int i = 0; i < WORDS; i++) exp_mem[i] = 16'hFFFF;
        do_pixel(17, 1, 1'b0);
        do_pixel(799, 479, 1'b0);
`else
        // Clear is not built: clear_req must not stall or start anything
        clear_req    = 1'b1;
        clear_colour = 1'b1;
        check("noclr_ready_high", px_ready, 1);
        step();
        clear_req = 1'b0;
        check("noclr_not_busy", busy, 0);
        check("noclr_no_we", ram_we, 0);
        step();
        check("noclr_done_low", clear_done, 0);
        clear_req = 1'b1;
        do_pixel(33, 2, 1'b1);
        clear_req = 1'b0;
        check("noclr_no_done_pulses", n_done, 0);
`endif

        // Reset in the middle of a pixel read-modify-write
        px_x = 11'd40; px_y = 11'd3; px_colour = 1'b1;
        px_valid = 1'b1;
        step();
        px_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rstpx_busy", busy, 0);
        check("rstpx_we", ram_we, 0);
        check("rstpx_rd_addr", ram_rd_address, 0);
        we0 = n_we;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("rstpx_no_writes", n_we - we0, 0);
        check("rstpx_ready", px_ready, 1);

`ifdef VGA_FB_CLEAR_EN
        // Reset while the clear is presenting word 100
        clear_colour = 1'b0;
        clear_req    = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        while (!(ram_we === 1'b1 && ram_wr_address === 16'd100) && n < 300) begin
            step();
            n++;
        end
        check("rstclr_reached_word_100", ram_wr_address, 100);
        reset_n = 1'b0;
        #1;
        we0 = n_we;
        check("rstclr_we", ram_we, 0);
        check("rstclr_busy", busy, 0);
        check("rstclr_done", clear_done, 0);
        check("rstclr_err", px_err, 0);
        check("rstclr_wr_addr", ram_wr_address, 0);
        check("rstclr_wr_data", ram_wr_data, 0);
        check("rstclr_rd_addr", ram_rd_address, 0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("rstclr_no_writes", n_we - we0, 0);
        check("rstclr_ready", px_ready, 1);
        for (int i = 0; i < 100; i++) exp_mem[i] = 16'h0000;
        do_pixel(50, 0, 1'b1);
        do_pixel(1600 % H, 101 * WB / H, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
